// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axil_pkg
// Purpose  : AXI4-Lite response codes, TX writer state type and strobe helper.
// Revision : 1.0  initial release
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } tx_state_t;

  function automatic logic resp_is_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

  // Strobe mask with the low nbytes lanes set (up to a 64-bit bus).
  function automatic logic [7:0] low_strb(input int nbytes);
    logic [7:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_tx_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_tx_writer_if
// Purpose  : AXI4-Lite write channels (AW, W, B) between TX writer and slave.
// Revision : 1.0  initial release
// ============================================================================
interface axil_tx_writer_if #(
  parameter int ADDR_W = 4,
  parameter int AXI_DW = 32
);
  import axil_pkg::*;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [AXI_DW-1:0]   wdata;
  logic [AXI_DW/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : single-clock FIFO with occupancy count; DEPTH must be a power of 2.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int                 c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]      c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == c_FULL);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly c_AW bits wide, so they wrap at DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_tx_writer.sv
`default_nettype none
// ============================================================================
// Module   : axil_tx_writer
// Purpose  : buffered AXI4-Lite write master feeding the UART TX data register.
//            Define TX_RETRY_EN to re-issue a word on error responses.
// Revision : 1.0  initial release
// ============================================================================
module axil_tx_writer
  import axil_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int AXI_DW     = 32,
  parameter int ADDR_W     = 4,
  parameter int TX_ADDR    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int RETRY_MAX  = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            data,
  input  logic                         send,
  output logic                         ready,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         busy,
  output logic                         err,
  axil_tx_writer_if.master             bus
);

  localparam logic [ADDR_W-1:0]   c_TX_ADDR = ADDR_W'(TX_ADDR);
  localparam logic [AXI_DW/8-1:0] c_WSTRB   = (AXI_DW/8)'(low_strb((DATA_W + 7) / 8));

  if (DATA_W > AXI_DW || FIFO_DEPTH < 2 || RETRY_MAX < 0) begin : g_param_check
    $error("axil_tx_writer: illegal parameter combination");
  end

  tx_state_t           r_state;
  tx_state_t           w_state_nxt;
  logic                r_aw_done;
  logic                r_w_done;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [AXI_DW-1:0]   r_wdata;
  logic [AXI_DW/8-1:0] r_wstrb;
  logic                r_err;
  logic                w_pop;
  logic                w_set_err;
  logic                w_awvalid;
  logic                w_wvalid;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [DATA_W-1:0]   w_fifo_dout;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (send),
    .pop     (w_pop),
    .din     (data),
    .dout    (w_fifo_dout),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .level   (level)
  );

  assign ready = !w_fifo_full;
  assign busy  = (r_state != IDLE) || !w_fifo_empty;
  assign err   = r_err;

  // Each valid is derived from its own done flag so AW and W retire independently.
  assign w_awvalid   = (r_state == ADDR) && !r_aw_done;
  assign w_wvalid    = (r_state == ADDR) && !r_w_done;
  assign w_aw_hs     = w_awvalid && bus.awready;
  assign w_w_hs      = w_wvalid && bus.wready;
  assign bus.awvalid = w_awvalid;
  assign bus.wvalid  = w_wvalid;
  assign bus.awaddr  = r_awaddr;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.bready  = (r_state == RESP);

`ifdef TX_RETRY_EN
  localparam int                c_RC_W      = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [c_RC_W-1:0] c_RETRY_MAX = c_RC_W'(RETRY_MAX);

  logic [c_RC_W-1:0] r_retry_cnt;
  logic              w_retry;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_set_err   = 1'b0;
`ifdef TX_RETRY_EN
    w_retry     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = RESP;
      end
      RESP: begin
        if (bus.bvalid) begin
          if (resp_is_ok(bus.bresp)) begin
            w_state_nxt = IDLE;
          end else begin
`ifdef TX_RETRY_EN
            if (r_retry_cnt < c_RETRY_MAX) begin
              w_retry     = 1'b1;
              w_state_nxt = ADDR;
            end else begin
              w_set_err   = 1'b1;
              w_state_nxt = IDLE;
            end
`else
            w_set_err   = 1'b1;
            w_state_nxt = IDLE;
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Done flags clear whenever ADDR is not the current state, so every entry
  // into ADDR (fresh word or retry) starts with both channels outstanding.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state != ADDR) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if (w_pop) begin
        r_awaddr <= c_TX_ADDR;
        r_wdata  <= AXI_DW'(w_fifo_dout);
        r_wstrb  <= c_WSTRB;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

`ifdef TX_RETRY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_retry_cnt <= '0;
    end else if ((r_state == RESP) && bus.bvalid) begin
      if (w_retry) r_retry_cnt <= r_retry_cnt + 1'b1;
      else         r_retry_cnt <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axil_tx_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_tx_writer
// Purpose  : self-checking bench for axil_tx_writer with a behavioural AXI-Lite slave.
// Revision : 1.0  initial release
// ============================================================================
module tb_axil_tx_writer;

  localparam int DATA_W     = 8;
  localparam int AXI_DW     = 32;
  localparam int ADDR_W     = 4;
  localparam int TX_ADDR    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int RETRY_MAX  = 3;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int EXP_STRB   = (1 << ((DATA_W + 7) / 8)) - 1;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              send    = 1'b0;
  logic [DATA_W-1:0] data    = '0;
  logic              ready;
  logic              busy;
  logic              err;
  logic [LVL_W-1:0]  level;

  axil_tx_writer_if #(.ADDR_W(ADDR_W), .AXI_DW(AXI_DW)) bus ();

  axil_tx_writer #(
    .DATA_W     (DATA_W),
    .AXI_DW     (AXI_DW),
    .ADDR_W     (ADDR_W),
    .TX_ADDR    (TX_ADDR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RETRY_MAX  (RETRY_MAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .data    (data),
    .send    (send),
    .ready   (ready),
    .level   (level),
    .busy    (busy),
    .err     (err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the words the slave must see, in order, and the sticky error.
  logic [AXI_DW-1:0] exp_data[$];
  logic              err_model = 1'b0;

  // Behavioural slave state, all updated on the falling edge.
  int                  aw_lat = 0, w_lat = 0, b_lat = 0;
  int                  aw_cnt, w_cnt, b_cnt;
  bit                  got_aw, got_w, pend_b;
  logic                p_awvalid, p_wvalid, p_bready;
  logic [ADDR_W-1:0]   p_awaddr, cap_addr;
  logic [AXI_DW-1:0]   p_wdata, cap_data;
  logic [AXI_DW/8-1:0] p_wstrb, cap_strb;
  logic [ADDR_W-1:0]   log_addr[$];
  logic [AXI_DW-1:0]   log_data[$];
  logic [AXI_DW/8-1:0] log_strb[$];
  logic [1:0]          resp_q[$];
  int                  n_b = 0, aw_hi = 0, w_hi = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      got_aw = 0; got_w = 0; pend_b = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      p_awvalid = 1'b0; p_wvalid = 1'b0; p_bready = 1'b0;
    end else begin
      // A valid seen last cycle without ready must still be up, payload unchanged.
      if (p_awvalid && !bus.awready) begin
        check("awvalid_held", bus.awvalid, 1'b1);
        check("awaddr_stable", bus.awaddr, p_awaddr);
      end
      if (p_wvalid && !bus.wready) begin
        check("wvalid_held", bus.wvalid, 1'b1);
        check("wdata_stable", bus.wdata, p_wdata);
      end
      if (p_awvalid && bus.awready) begin got_aw = 1; cap_addr = p_awaddr; end
      if (p_wvalid && bus.wready) begin got_w = 1; cap_data = p_wdata; cap_strb = p_wstrb; end
      if (bus.bvalid && p_bready) begin bus.bvalid = 1'b0; n_b++; end
      if (got_aw && got_w) begin
        log_addr.push_back(cap_addr);
        log_data.push_back(cap_data);
        log_strb.push_back(cap_strb);
        got_aw = 0; got_w = 0; pend_b = 1; b_cnt = 0;
      end
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid)  w_hi++;
      bus.awready = bus.awvalid && (aw_cnt >= aw_lat);
      if (bus.awvalid && !bus.awready) aw_cnt++; else aw_cnt = 0;
      bus.wready = bus.wvalid && (w_cnt >= w_lat);
      if (bus.wvalid && !bus.wready) w_cnt++; else w_cnt = 0;
      if (pend_b && !bus.bvalid) begin
        if (b_cnt >= b_lat) begin
          bus.bvalid = 1'b1;
          bus.bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          pend_b     = 0;
        end else begin
          b_cnt++;
        end
      end
      p_awvalid = bus.awvalid; p_awaddr = bus.awaddr;
      p_wvalid  = bus.wvalid;  p_wdata  = bus.wdata; p_wstrb = bus.wstrb;
      p_bready  = bus.bready;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [DATA_W-1:0] b);
    data = b;
    send = 1'b1;
    cyc();
    send = 1'b0;
  endtask

  task automatic expect_word(input logic [DATA_W-1:0] b);
    exp_data.push_back(AXI_DW'(b));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (log_data.size() < exp_data.size() && t < 600) begin cyc(); t++; end
    t = 0;
    while (busy !== 1'b0 && t < 200) begin cyc(); t++; end
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_count"}, log_data.size(), exp_data.size());
    while (log_data.size() > 0 && exp_data.size() > 0) begin
      check({tag, "_addr"}, log_addr.pop_front(), TX_ADDR);
      check({tag, "_strb"}, log_strb.pop_front(), EXP_STRB);
      check({tag, "_data"}, log_data.pop_front(), exp_data.pop_front());
    end
    check({tag, "_err"}, err, err_model);
    exp_data.delete(); log_addr.delete(); log_data.delete(); log_strb.delete();
  endtask

  initial begin
    int model_level;
    int nb0;
    int t;
    int len;
    logic [DATA_W-1:0] b;
    logic [1:0]        r;

    // Reset state
    reset_n = 1'b0;
    repeat (3) cyc();
    check("rst_awvalid", bus.awvalid, 1'b0);
    check("rst_wvalid",  bus.wvalid,  1'b0);
    check("rst_bready",  bus.bready,  1'b0);
    check("rst_awaddr",  bus.awaddr,  0);
    check("rst_wdata",   bus.wdata,   0);
    check("rst_wstrb",   bus.wstrb,   0);
    check("rst_err",     err,   1'b0);
    check("rst_ready",   ready, 1'b1);
    check("rst_level",   level, 0);
    check("rst_busy",    busy,  1'b0);
    reset_n = 1'b1;
    cyc();

    // 1: single byte, zero-wait slave, awvalid two cycles after send
    push_byte(8'hA5);
    expect_word(8'hA5);
    check("t1_aw_early", bus.awvalid, 1'b0);
    cyc();
    check("t1_awvalid", bus.awvalid, 1'b1);
    check("t1_wvalid",  bus.wvalid,  1'b1);
    check("t1_awaddr",  bus.awaddr,  TX_ADDR);
    check("t1_wdata",   bus.wdata,   32'h0000_00A5);
    check("t1_wstrb",   bus.wstrb,   EXP_STRB);
    check("t1_bready",  bus.bready,  1'b0);
    drain("t1");

    // 2: AW accepted three cycles late, W immediate
    aw_lat = 3; aw_hi = 0; w_hi = 0; nb0 = n_b;
    push_byte(8'h3C);
    expect_word(8'h3C);
    drain("t2");
    check("t2_aw_cycles", aw_hi, 4);
    check("t2_w_cycles",  w_hi,  1);
    check("t2_b_count",   n_b - nb0, 1);
    aw_lat = 0;

    // 3: fill the FIFO while the slave stalls AW; the ninth push is dropped
    aw_lat = 1000;
    b = 8'($urandom);
    push_byte(b);
    expect_word(b);
    repeat (2) cyc();
    model_level = 0;
    for (int i = 0; i < 9; i++) begin
      check("t3_ready", ready, (model_level < FIFO_DEPTH));
      check("t3_level", level, model_level);
      b = 8'($urandom);
      push_byte(b);
      if (model_level < FIFO_DEPTH) begin
        expect_word(b);
        model_level++;
      end
    end
    check("t3_full_level", level, FIFO_DEPTH);
    check("t3_full_ready", ready, 1'b0);
    aw_lat = 0;
    drain("t3");

    // 4: push coinciding with the pop that follows a B handshake, level 3
    aw_lat = 1000;
    push_byte(8'h10);
    expect_word(8'h10);
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) begin
      push_byte(8'h11 + 8'(i));
      expect_word(8'h11 + 8'(i));
    end
    check("t4_level_pre", level, 3);
    nb0 = n_b;
    aw_lat = 0;
    t = 0;
    while (n_b == nb0 && t < 50) begin cyc(); t++; end
    check("t4_b_seen", (n_b != nb0), 1'b1);
    push_byte(8'h77);
    expect_word(8'h77);
    check("t4_level_same", level, 3);
    drain("t4");

    // 5: error responses
`ifdef TX_RETRY_EN
    resp_q.push_back(2'b10);
    resp_q.push_back(2'b10);
    resp_q.push_back(2'b00);
    push_byte(8'hE1);
    push_byte(8'hE2);
    repeat (3) expect_word(8'hE1);
    expect_word(8'hE2);
    drain("t5_retry");
    for (int i = 0; i <= RETRY_MAX; i++) resp_q.push_back(2'b10);
    push_byte(8'hE3);
    repeat (RETRY_MAX + 1) expect_word(8'hE3);
    err_model = 1'b1;
    drain("t5_exhaust");
`else
    resp_q.push_back(2'b10);
    push_byte(8'hE1);
    push_byte(8'hE2);
    expect_word(8'hE1);
    expect_word(8'hE2);
    err_model = 1'b1;
    drain("t5_err");
`endif

    // 6: reset while in ADDR with five bytes queued
    aw_lat = 1000;
    push_byte(8'h60);
    repeat (2) cyc();
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
    check("t6_level_pre", level, 5);
    check("t6_aw_pre", bus.awvalid, 1'b1);
    reset_n = 1'b0;
    cyc();
    check("t6_awvalid", bus.awvalid, 1'b0);
    check("t6_wvalid",  bus.wvalid,  1'b0);
    check("t6_bready",  bus.bready,  1'b0);
    check("t6_level",   level, 0);
    check("t6_ready",   ready, 1'b1);
    check("t6_err",     err,   1'b0);
    reset_n = 1'b1;
    aw_lat = 0;
    err_model = 1'b0;
    resp_q.delete();
    exp_data.delete(); log_addr.delete(); log_data.delete(); log_strb.delete();
    repeat (4) cyc();
    check("t6_no_write", log_data.size(), 0);
    check("t6_idle", busy, 1'b0);

    // Random bursts, each no longer than the FIFO so nothing is dropped
    for (int burst = 0; burst < 8; burst++) begin
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      b_lat  = $urandom_range(0, 3);
      len    = $urandom_range(1, FIFO_DEPTH);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
`ifndef TX_RETRY_EN
        r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
        resp_q.push_back(r);
        if (r >= 2'b10) err_model = 1'b1;
`endif
        push_byte(b);
        expect_word(b);
        repeat ($urandom_range(0, 2)) cyc();
      end
      drain("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
